signal_conflict_monitor: RTL

- Safety stage directly downstream of traffic_light_controller.
- Samples the controller's four 3-bit light vectors (M1, S, MT, M2) and passes them to the lamp drivers with one cycle of registered delay.
- Checks every sample for illegal encodings, conflicting greens and illegal phase sequences.
- On any violation, latches a fault and overrides every lamp with flashing red until an operator clears it and an all-red recovery hold has elapsed.

---
 rtl/signal_conflict_monitor.sv | 114 +++++++++++
 1 files changed

// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor: registered lamp passthrough with conflict/sequence checking and latched flashing-red fault; FAULT_COUNT_EN adds fault_count.
module signal_conflict_monitor #(
  parameter int MIN_YELLOW   = 3,
  parameter int FLASH_HALF   = 4,
  parameter int ALL_RED_HOLD = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1_in,
  input  logic [2:0] light_s_in,
  input  logic [2:0] light_MT_in,
  input  logic [2:0] light_M2_in,
  input  logic       fault_clr,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_s,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_M2,
  output logic       fault,
  output logic [2:0] fault_code
`ifdef FAULT_COUNT_EN
  ,
  output logic [7:0] fault_count
`endif
);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam int HW = $clog2(ALL_RED_HOLD + 1);
  localparam logic [2:0] RED = 3'b001, YEL = 3'b010, GRN = 3'b100;
  typedef enum logic [1:0] {PASS, FAULT, RECOVER} state_t;
  state_t state;
  logic [3:0][2:0] smp, prev, lamp;
  logic [3:0][YW-1:0] ycnt;
  logic [3:0] bad, grn, g2r, y2r, y2g;
  logic [FW-1:0] flash, flash_nx;
  logic [HW-1:0] hold;
  logic [2:0] code;
  logic conflict;
  // channel order 0..3 = M1, S, MT, M2
  assign smp = {light_M2_in, light_MT_in, light_s_in, light_M1_in};
  assign {lamp_M2, lamp_MT, lamp_s, lamp_M1} = lamp;
  assign flash_nx = flash == FW'(2 * FLASH_HALF - 1) ? '0 : flash + 1'b1;
  always_comb begin
    bad = '0;
    grn = '0;
    g2r = '0;
    y2r = '0;
    y2g = '0;
    for (int i = 0; i < 4; i++) begin
      bad[i] = smp[i] != RED && smp[i] != YEL && smp[i] != GRN;
      grn[i] = smp[i] == GRN;
      g2r[i] = prev[i] == GRN && smp[i] == RED;
      y2r[i] = prev[i] == YEL && smp[i] == RED && ycnt[i] < YW'(MIN_YELLOW);
      y2g[i] = prev[i] == YEL && smp[i] == GRN;
    end
    conflict = (grn[1] && (grn[0] || grn[2] || grn[3])) || (grn[2] && grn[3]);
    code = |bad ? 3'd1 : conflict ? 3'd2 : |g2r ? 3'd3 : |y2r ? 3'd4 : |y2g ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RECOVER;
      hold       <= '0;
      flash      <= '0;
      lamp       <= {4{RED}};
      fault      <= 1'b0;
      fault_code <= '0;
      prev       <= {4{RED}};
      ycnt       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        prev[i] <= smp[i];
        ycnt[i] <= smp[i] != YEL ? '0 : ycnt[i] == YW'(MIN_YELLOW) ? ycnt[i] : ycnt[i] + 1'b1;
      end
      // a clear in FAULT outranks any same-cycle violation
      if (state != FAULT && code != 3'd0) begin
        state      <= FAULT;
        fault_code <= code;
        fault      <= 1'b1;
        flash      <= '0;
        lamp       <= {4{RED}};
      end else begin
        case (state)
          PASS: lamp <= smp;
          FAULT: begin
            if (fault_clr) begin
              state <= RECOVER;
              hold  <= '0;
              lamp  <= {4{RED}};
            end else begin
              flash <= flash_nx;
              lamp  <= flash_nx < FW'(FLASH_HALF) ? {4{RED}} : '0;
            end
          end
          RECOVER: begin
            lamp <= {4{RED}};
            if (hold == HW'(ALL_RED_HOLD - 1)) begin
              state      <= PASS;
              fault      <= 1'b0;
              fault_code <= '0;
            end else begin
              hold <= hold + 1'b1;
            end
          end
          default: state <= RECOVER;
        endcase
      end
    end
  end
`ifdef FAULT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fault_count <= '0;
    else if (state != FAULT && code != 3'd0 && fault_count != 8'hff) fault_count <= fault_count + 1'b1;
  end
`endif
endmodule
